// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: holds one fetched instruction behind a valid/ready
// handshake, breaks out its fields and drives one-hot execute-unit enables.
module rv32i_decode_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  input  logic [31:0]            pc_in,
  output logic                   instr_ready,
  output logic                   decode_valid,
  input  logic                   decode_ready,
  output logic [31:0]            pc_out,
  output logic [4:0]             rd_index,
  output logic [4:0]             rs1_index,
  output logic [4:0]             rs2_index,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [31:0]            immediate12_itype,
  output logic [31:0]            immediate12_stype,
  output logic [31:0]            immediate13_btype,
  output logic [31:0]            immediate20_utype,
  output logic [31:0]            immediate21_jtype,
  output logic                   alu_upper_immediate_lui_enable,
  output logic                   alu_upper_immediate_auipc_enable,
  output logic                   alu_immediate_enable,
  output logic                   alu_register_enable,
  output logic                   load_enable,
  output logic                   store_enable,
  output logic                   branch_enable,
  output logic                   jal_enable,
  output logic                   jalr_enable,
  output logic                   illegal_instruction,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] decoded_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q;
  logic [31:0]            pc_q;
  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic       accept;
  logic       handoff;
  logic       known_op;
  logic [8:0] op_onehot;

  // Opcode classification; a full 7-bit match also rejects instr[1:0] != 2'b11.
  always_comb begin
    op_onehot = '0;
    known_op  = 1'b1;
    case (instr_q[6:0])
      7'b0110111: op_onehot[8] = 1'b1;
      7'b0010111: op_onehot[7] = 1'b1;
      7'b0010011: op_onehot[6] = 1'b1;
      7'b0110011: op_onehot[5] = 1'b1;
      7'b0000011: op_onehot[4] = 1'b1;
      7'b0100011: op_onehot[3] = 1'b1;
      7'b1100011: op_onehot[2] = 1'b1;
      7'b1101111: op_onehot[1] = 1'b1;
      7'b1100111: op_onehot[0] = 1'b1;
      default:    known_op     = 1'b0;
    endcase
  end

  assign handoff = valid_q && decode_ready;
  assign accept  = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // An illegal word being handed off blocks the refill at that same edge.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    case (state_q)
      RUN: begin
        instr_ready = !valid_q || (decode_ready && known_op);
        if (handoff && !known_op) state_d = HALT;
      end
      HALT: begin
        instr_ready = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr;
        pc_q    <= pc_in;
        valid_q <= 1'b1;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
      if (handoff) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign decode_valid  = valid_q;
  assign halted        = (state_q == HALT);
  assign decoded_count = count_q;
  assign pc_out        = valid_q ? pc_q : RESET_PC;

  assign rd_index  = instr_q[11:7];
  assign rs1_index = instr_q[19:15];
  assign rs2_index = instr_q[24:20];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];

  assign immediate12_itype = {{20{instr_q[31]}}, instr_q[31:20]};
  assign immediate12_stype = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign immediate13_btype = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                              instr_q[30:25], instr_q[11:8], 1'b0};
  assign immediate20_utype = {instr_q[31:12], 12'b0};
  assign immediate21_jtype = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                              instr_q[20], instr_q[30:21], 1'b0};

  assign alu_upper_immediate_lui_enable   = valid_q && op_onehot[8];
  assign alu_upper_immediate_auipc_enable = valid_q && op_onehot[7];
  assign alu_immediate_enable             = valid_q && op_onehot[6];
  assign alu_register_enable              = valid_q && op_onehot[5];
  assign load_enable                      = valid_q && op_onehot[4];
  assign store_enable                     = valid_q && op_onehot[3];
  assign branch_enable                    = valid_q && op_onehot[2];
  assign jal_enable                       = valid_q && op_onehot[1];
  assign jalr_enable                      = valid_q && op_onehot[0];
  assign illegal_instruction              = valid_q && !known_op;

endmodule
